// File: rtl/cpu_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and requester ids.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) round-robin arbiter onto a single shared memory port.
// One outstanding transaction; a BUSY-cycle watchdog aborts stalled accesses.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t        state_reg;
    state_t        state_next;
    logic          owner_reg;
    logic          last_gnt_reg;
    logic [AW-1:0] addr_reg;
    logic          we_reg;
    logic [DW-1:0] wdata_reg;
    logic [7:0]    cnt_reg;
    logic          err_reg;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] dm_rdata_reg;

    logic any_req;
    logic winner;
    logic timed_out;

    assign any_req   = if_req | dm_req;
    // Contention goes to whichever port did not win last time.
    assign winner    = (if_req && dm_req) ? ~last_gnt_reg : dm_req;
    assign timed_out = (cnt_reg == TIMEOUT_CNT);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (any_req) state_next = BUSY;
            BUSY: if (mem_ack || timed_out) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            owner_reg    <= PORT_IF;
            last_gnt_reg <= PORT_IF;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
            if_rdata_reg <= '0;
            dm_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        owner_reg    <= winner;
                        last_gnt_reg <= winner;
                        addr_reg     <= (winner == PORT_DM) ? dm_addr : if_addr;
                        we_reg       <= (winner == PORT_DM) && dm_we;
                        wdata_reg    <= (winner == PORT_DM) ? dm_wdata : '0;
                        cnt_reg      <= 8'd1;
                        err_reg      <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        err_reg <= 1'b0;
                        // Writes leave the read-data register untouched.
                        if (!we_reg) begin
                            if (owner_reg == PORT_DM) dm_rdata_reg <= mem_rdata;
                            else                      if_rdata_reg <= mem_rdata;
                        end
                    end else if (timed_out) begin
                        err_reg <= 1'b1;
                        if (owner_reg == PORT_DM) dm_rdata_reg <= '0;
                        else                      if_rdata_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                RESP: begin
                    cnt_reg <= '0;
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

    logic busy;
    logic resp;
    logic first_busy;

    assign busy       = (state_reg == BUSY);
    assign resp       = (state_reg == RESP);
    assign first_busy = busy && (cnt_reg == 8'd1);

    assign if_gnt    = first_busy && (owner_reg == PORT_IF);
    assign dm_gnt    = first_busy && (owner_reg == PORT_DM);
    assign if_rvalid = resp && (owner_reg == PORT_IF);
    assign dm_rvalid = resp && (owner_reg == PORT_DM);
    assign err       = resp && err_reg;
    assign if_rdata  = if_rdata_reg;
    assign dm_rdata  = dm_rdata_reg;

    assign mem_req   = busy;
    assign mem_we    = busy && we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every
// cycle, plus literal expectations for grant order, pulse counts and data.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          Reset_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one pending transaction, tracked by how many BUSY cycles
    // it has spent and whether it is in its response cycle.
    logic          m_active = 1'b0;
    logic          m_resp = 1'b0;
    int            m_busy = 0;
    logic          m_owner = 1'b0;
    logic          m_last = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic          m_we = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    logic          m_err = 1'b0;
    logic [DW-1:0] m_rd_if = '0;
    logic [DW-1:0] m_rd_dm = '0;

    always @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            m_active <= 1'b0; m_resp <= 1'b0; m_busy <= 0; m_owner <= 1'b0;
            m_last <= 1'b0; m_addr <= '0; m_we <= 1'b0; m_wdata <= '0;
            m_err <= 1'b0; m_rd_if <= '0; m_rd_dm <= '0;
        end else if (!m_active) begin
            if (if_req || dm_req) begin
                logic w;
                w = (if_req && dm_req) ? !m_last : dm_req;
                m_active <= 1'b1; m_resp <= 1'b0; m_busy <= 1;
                m_owner <= w; m_last <= w;
                m_addr  <= w ? dm_addr : if_addr;
                m_we    <= w ? dm_we : 1'b0;
                m_wdata <= w ? dm_wdata : '0;
            end
        end else if (!m_resp) begin
            if (mem_ack) begin
                m_resp <= 1'b1; m_err <= 1'b0;
                if (!m_we) begin
                    if (m_owner) m_rd_dm <= mem_rdata; else m_rd_if <= mem_rdata;
                end
            end else if (m_busy == TO) begin
                m_resp <= 1'b1; m_err <= 1'b1;
                if (m_owner) m_rd_dm <= '0; else m_rd_if <= '0;
            end else begin
                m_busy <= m_busy + 1;
            end
        end else begin
            m_active <= 1'b0; m_resp <= 1'b0;
        end
    end

    // Event monitor for the literal checks
    int   c_if_gnt, c_dm_gnt, c_if_rv, c_dm_rv, c_err, c_req, c_we;
    logic [7:0] order_bits;
    int   order_len;

    task automatic clr_mon();
        c_if_gnt = 0; c_dm_gnt = 0; c_if_rv = 0; c_dm_rv = 0;
        c_err = 0; c_req = 0; c_we = 0; order_bits = '0; order_len = 0;
    endtask

    always @(negedge CLK) begin
        logic e_req;
        e_req = m_active && !m_resp;
        chk("mem_req",   {63'd0, mem_req},   {63'd0, e_req});
        chk("mem_we",    {63'd0, mem_we},    {63'd0, e_req && m_we});
        chk("if_gnt",    {63'd0, if_gnt},    {63'd0, e_req && m_busy == 1 && !m_owner});
        chk("dm_gnt",    {63'd0, dm_gnt},    {63'd0, e_req && m_busy == 1 && m_owner});
        chk("if_rvalid", {63'd0, if_rvalid}, {63'd0, m_resp && !m_owner});
        chk("dm_rvalid", {63'd0, dm_rvalid}, {63'd0, m_resp && m_owner});
        chk("err",       {63'd0, err},       {63'd0, m_resp && m_err});
        chk("if_rdata",  64'(if_rdata), 64'(m_rd_if));
        chk("dm_rdata",  64'(dm_rdata), 64'(m_rd_dm));
        if (e_req) begin
            chk("mem_addr",  64'(mem_addr),  64'(m_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        if (if_gnt) begin c_if_gnt++; order_bits = {order_bits[6:0], 1'b0}; order_len++; end
        if (dm_gnt) begin c_dm_gnt++; order_bits = {order_bits[6:0], 1'b1}; order_len++; end
        if (if_rvalid) c_if_rv++;
        if (dm_rvalid) c_dm_rv++;
        if (err) c_err++;
        if (mem_req) c_req++;
        if (mem_req && mem_we) c_we++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait for a grant, optionally drop requests, ack after 'delay' more cycles.
    // drop: 0 keep both, 1 drop the granted port, 2 drop both.
    task automatic serve(input int delay, input logic [DW-1:0] data, input int drop);
        int n;
        n = 0;
        while (!mem_req && n < 40) begin
            tick();
            n++;
        end
        chk("grant_wait", {63'd0, mem_req}, 64'd1);
        if (drop == 2) begin
            if_req = 1'b0; dm_req = 1'b0;
        end else if (drop == 1) begin
            if (if_gnt) if_req = 1'b0;
            if (dm_gnt) dm_req = 1'b0;
        end
        repeat (delay) tick();
        mem_ack = 1'b1; mem_rdata = data;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_mon();
        repeat (3) tick();
        chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
        chk("reset_if_rdata", 64'(if_rdata), 64'd0);
        Reset_n = 1'b1;
        tick();

        // Single fetch read, ack two cycles after grant
        clr_mon();
        if_req = 1'b1; if_addr = 32'h40;
        serve(2, 32'hDEADBEEF, 1);
        tick();
        chk("t1_if_gnt_cnt", 64'(c_if_gnt), 64'd1);
        chk("t1_if_rv_cnt",  64'(c_if_rv),  64'd1);
        chk("t1_if_rdata",   64'(if_rdata), 64'hDEADBEEF);
        chk("t1_err_cnt",    64'(c_err),    64'd0);
        chk("t1_busy_len",   64'(c_req),    64'd3);

        // Simultaneous requests: data port wins first, then fetch
        clr_mon();
        if_req = 1'b1; if_addr = 32'h44;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        serve(0, 32'hA0A0A0A0, 1);
        serve(1, 32'hB1B1B1B1, 1);
        tick();
        chk("t2_order_len", 64'(order_len), 64'd2);
        chk("t2_order", 64'(order_bits), 64'h02);
        chk("t2_dm_rdata", 64'(dm_rdata), 64'hA0A0A0A0);
        chk("t2_if_rdata", 64'(if_rdata), 64'hB1B1B1B1);

        // Both held high: alternating grants
        clr_mon();
        if_req = 1'b1; if_addr = 32'h48;
        dm_req = 1'b1; dm_addr = 32'h84;
        serve(0, 32'h11110001, 0);
        serve(1, 32'h22220002, 0);
        serve(0, 32'h33330003, 0);
        serve(2, 32'h44440004, 2);
        tick();
        chk("t3_order_len", 64'(order_len), 64'd4);
        chk("t3_order", 64'(order_bits), 64'h0A);
        chk("t3_dm_rdata", 64'(dm_rdata), 64'h33330003);
        chk("t3_if_rdata", 64'(if_rdata), 64'h44440004);

        // Data write: read data register must not change
        clr_mon();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'h1234;
        serve(1, 32'hBAD0BAD0, 1);
        dm_we = 1'b0; dm_wdata = '0;
        tick();
        chk("t4_dm_rv_cnt", 64'(c_dm_rv),  64'd1);
        chk("t4_we_cycles", 64'(c_we),     64'd2);
        chk("t4_dm_rdata",  64'(dm_rdata), 64'h33330003);

        // Timeout: no ack within TO busy cycles, late ack ignored
        clr_mon();
        dm_req = 1'b1; dm_addr = 32'h88;
        serve(TO + 4, 32'h55555555, 1);
        tick();
        chk("t5_busy_len",  64'(c_req),    64'(TO));
        chk("t5_err_cnt",   64'(c_err),    64'd1);
        chk("t5_dm_rv_cnt", 64'(c_dm_rv),  64'd1);
        chk("t5_dm_rdata",  64'(dm_rdata), 64'd0);

        // Reset in the middle of BUSY
        clr_mon();
        dm_req = 1'b1; dm_addr = 32'h20;
        tick();
        dm_req = 1'b0;
        tick();
        Reset_n = 1'b0;
        #1;
        chk("t6_req_in_reset", {63'd0, mem_req}, 64'd0);
        chk("t6_addr_in_reset", 64'(mem_addr), 64'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        chk("t6_no_rvalid", 64'(c_dm_rv + c_if_rv), 64'd0);
        if_req = 1'b1; if_addr = 32'h4C;
        serve(0, 32'hCAFEF00D, 1);
        tick();
        chk("t6_if_rv_cnt", 64'(c_if_rv),  64'd1);
        chk("t6_if_rdata",  64'(if_rdata), 64'hCAFEF00D);
        chk("t6_dm_rdata",  64'(dm_rdata), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
